// File: rtl/latch_seq_pkg.sv
// Shared types and helpers for the latch bank write sequencer.
package latch_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   localparam int DW_DEF = 4;

   // Ceiling log2, never less than 1 so single-bit indices stay legal.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/latch_bank_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr wins.
module rr_arbiter
   import latch_seq_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   logic w_found;
   int   w_cand;

   always_comb begin
      gnt     = '0;
      idx     = '0;
      w_found = 1'b0;
      w_cand  = 0;
      for (int k = 0; k < N; k++) begin
         w_cand = (int'(ptr) + k) % N;
         if (!w_found && req[w_cand]) begin
            w_found     = 1'b1;
            gnt[w_cand] = 1'b1;
            idx         = IW'(w_cand);
         end
      end
   end

endmodule

// File: rtl/latch_bank_sequencer.sv
// Round-robin write sequencer driving a shared bank of level-sensitive latch words
// with a setup / one-cycle strobe / hold pattern around each enable pulse.
module latch_bank_sequencer
   import latch_seq_pkg::*;
#(
   parameter  int NREQ   = 4,
   parameter  int NWORDS = 4,
   parameter  int DW     = DW_DEF,
   localparam int AW     = clog2(NWORDS),
   localparam int IW     = clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] wr_data,
   input  logic [NREQ*AW-1:0] wr_addr,
   output logic [NREQ-1:0]    ack,
   output logic               wr_err,
   output logic               busy,
   output logic [IW-1:0]      gnt_id,
   output logic [DW-1:0]      lat_d,
   output logic [NWORDS-1:0]  lat_en
);

   state_t              r_state;
   logic [NREQ-1:0]     r_gnt_oh;
   logic [IW-1:0]       r_gnt_id;
   logic [IW-1:0]       r_ptr;
   logic [AW-1:0]       r_addr;
   logic [DW-1:0]       r_lat_d;
   logic [NWORDS-1:0]   r_lat_en;
   logic [NREQ-1:0]     r_ack;
   logic                r_err;
   logic                r_busy;

   logic [NREQ-1:0]     w_gnt;
   logic [IW-1:0]       w_idx;
   logic                w_in_range;
   logic [NWORDS-1:0]   w_dec;
   logic [IW-1:0]       w_ptr_nxt;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req (req),
      .ptr (r_ptr),
      .gnt (w_gnt),
      .idx (w_idx)
   );

   // Address widths can exceed the bank size when NWORDS is not a power of two.
   assign w_in_range = (int'(r_addr) < NWORDS);
   assign w_dec      = w_in_range ? (NWORDS'(1) << r_addr) : '0;
   assign w_ptr_nxt  = (int'(r_gnt_id) == NREQ - 1) ? '0 : r_gnt_id + IW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_gnt_oh <= '0;
         r_gnt_id <= '0;
         r_ptr    <= '0;
         r_lat_d  <= '0;
         r_lat_en <= '0;
         r_ack    <= '0;
         r_err    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_ack    <= '0;
               r_err    <= 1'b0;
               r_lat_en <= '0;
               if (|req) begin
                  r_gnt_oh <= w_gnt;
                  r_gnt_id <= w_idx;
                  r_addr   <= wr_addr[int'(w_idx)*AW +: AW];
                  r_lat_d  <= wr_data[int'(w_idx)*DW +: DW];
                  r_busy   <= 1'b1;
                  r_state  <= SETUP;
               end else begin
                  r_busy   <= 1'b0;
               end
            end
            SETUP: begin
               r_lat_en <= w_dec;
               r_state  <= STROBE;
            end
            STROBE: begin
               r_lat_en <= '0;
               r_ack    <= r_gnt_oh;
               r_err    <= !w_in_range;
               r_ptr    <= w_ptr_nxt;
               r_state  <= HOLD;
            end
            HOLD: begin
               r_ack    <= '0;
               r_err    <= 1'b0;
               r_busy   <= 1'b0;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ack    = r_ack;
   assign wr_err = r_err;
   assign busy   = r_busy;
   assign gnt_id = r_gnt_id;
   assign lat_d  = r_lat_d;
   assign lat_en = r_lat_en;

endmodule

// File: tb/tb_latch_bank_sequencer.sv
// Directed bench: a 4-word instance and a 3-word instance share the same stimulus.
module tb_latch_bank_sequencer;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] wr_data;
   logic [7:0]  wr_addr;

   logic [3:0]  ack_a,    ack_b;
   logic        err_a,    err_b;
   logic        busy_a,   busy_b;
   logic [1:0]  gnt_a,    gnt_b;
   logic [3:0]  lat_d_a,  lat_d_b;
   logic [3:0]  lat_en_a;
   logic [2:0]  lat_en_b;

   int n_assert;
   int n_fail;

   latch_bank_sequencer #(.NREQ(4), .NWORDS(4), .DW(4)) u_dut_a (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .wr_data (wr_data),
      .wr_addr (wr_addr),
      .ack     (ack_a),
      .wr_err  (err_a),
      .busy    (busy_a),
      .gnt_id  (gnt_a),
      .lat_d   (lat_d_a),
      .lat_en  (lat_en_a)
   );

   latch_bank_sequencer #(.NREQ(4), .NWORDS(3), .DW(4)) u_dut_b (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .wr_data (wr_data),
      .wr_addr (wr_addr),
      .ack     (ack_b),
      .wr_err  (err_b),
      .busy    (busy_b),
      .gnt_id  (gnt_b),
      .lat_d   (lat_d_b),
      .lat_en  (lat_en_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [3:0] d, input logic [1:0] a);
      wr_data[i*4 +: 4] = d;
      wr_addr[i*2 +: 2] = a;
   endtask

   // One full sequence on the 4-word instance, ending in the following IDLE cycle.
   task automatic seq_a(input string tag, input int g, input logic [3:0] d, input logic [3:0] en);
      tick();
      chk({tag, " setup gnt"},    32'(gnt_a),    32'(g));
      chk({tag, " setup lat_d"},  32'(lat_d_a),  32'(d));
      chk({tag, " setup lat_en"}, 32'(lat_en_a), 32'h0);
      chk({tag, " setup busy"},   32'(busy_a),   32'h1);
      tick();
      chk({tag, " strobe lat_en"}, 32'(lat_en_a), 32'(en));
      chk({tag, " strobe lat_d"},  32'(lat_d_a),  32'(d));
      chk({tag, " strobe ack"},    32'(ack_a),    32'h0);
      tick();
      chk({tag, " hold lat_en"}, 32'(lat_en_a), 32'h0);
      chk({tag, " hold ack"},    32'(ack_a),    32'(4'(1) << g));
      chk({tag, " hold err"},    32'(err_a),    32'h0);
      chk({tag, " hold busy"},   32'(busy_a),   32'h1);
      tick();
      chk({tag, " idle ack"},   32'(ack_a),   32'h0);
      chk({tag, " idle busy"},  32'(busy_a),  32'h0);
      chk({tag, " idle lat_d"}, 32'(lat_d_a), 32'(d));
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst      = 1'b1;
      req      = '0;
      wr_data  = '0;
      wr_addr  = '0;
      tick();
      tick();
      rst = 1'b0;

      chk("reset lat_en", 32'(lat_en_a), 32'h0);
      chk("reset lat_d",  32'(lat_d_a),  32'h0);
      chk("reset ack",    32'(ack_a),    32'h0);
      chk("reset err",    32'(err_a),    32'h0);
      chk("reset busy",   32'(busy_a),   32'h0);
      chk("reset gnt",    32'(gnt_a),    32'h0);

      // Single write
      set_req(0, 4'b1010, 2'd2);
      req = 4'b0001;
      seq_a("single", 0, 4'b1010, 4'b0100);
      req = 4'b0000;

      // All four requesters, each dropping its request after its ack
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, 4'(1) << i, 2'(i));
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         seq_a($sformatf("all%0d", k), k, 4'(1) << k, 4'(1) << k);
         req[k] = 1'b0;
      end

      // Fairness between requesters 0 and 1
      req = 4'b0010;
      seq_a("rr first", 1, 4'b0010, 4'b0010);
      req = 4'b0011;
      seq_a("rr a", 0, 4'b0001, 4'b0001);
      seq_a("rr b", 1, 4'b0010, 4'b0010);
      seq_a("rr c", 0, 4'b0001, 4'b0001);
      seq_a("rr d", 1, 4'b0010, 4'b0010);
      req = 4'b0000;

      // Address 3 is out of range only for the 3-word instance
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_req(0, 4'b1111, 2'd3);
      req = 4'b0001;
      tick();
      req = 4'b0000;
      chk("oor setup lat_d",  32'(lat_d_b),  32'hF);
      chk("oor setup lat_en", 32'(lat_en_b), 32'h0);
      chk("oor setup busy",   32'(busy_b),   32'h1);
      tick();
      chk("oor strobe lat_en",  32'(lat_en_b), 32'h0);
      chk("inr strobe lat_en",  32'(lat_en_a), 32'h8);
      tick();
      chk("oor hold lat_en", 32'(lat_en_b), 32'h0);
      chk("oor hold ack",    32'(ack_b),    32'h1);
      chk("oor hold err",    32'(err_b),    32'h1);
      chk("inr hold ack",    32'(ack_a),    32'h1);
      chk("inr hold err",    32'(err_a),    32'h0);
      tick();
      chk("oor idle ack", 32'(ack_b), 32'h0);
      chk("oor idle err", 32'(err_b), 32'h0);

      // Reset during the strobe cycle
      set_req(0, 4'b0101, 2'd1);
      req = 4'b0001;
      tick();
      req = 4'b0000;
      tick();
      chk("abort strobe lat_en", 32'(lat_en_a), 32'h2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort lat_en", 32'(lat_en_a), 32'h0);
      chk("abort ack",    32'(ack_a),    32'h0);
      chk("abort busy",   32'(busy_a),   32'h0);
      chk("abort lat_d",  32'(lat_d_a),  32'h0);
      set_req(2, 4'b0011, 2'd0);
      req = 4'b0100;
      seq_a("after abort", 2, 4'b0011, 4'b0001);
      req = 4'b0000;

      // Inputs changed after grant must not disturb the write
      set_req(3, 4'b0110, 2'd1);
      req = 4'b1000;
      tick();
      chk("late setup lat_d", 32'(lat_d_a), 32'h6);
      chk("late setup gnt",   32'(gnt_a),   32'h3);
      set_req(3, 4'b1001, 2'd2);
      req = 4'b0000;
      tick();
      chk("late strobe lat_en", 32'(lat_en_a), 32'h2);
      chk("late strobe lat_d",  32'(lat_d_a),  32'h6);
      tick();
      chk("late hold ack",   32'(ack_a),   32'h8);
      chk("late hold lat_d", 32'(lat_d_a), 32'h6);
      tick();
      chk("late idle lat_en", 32'(lat_en_a), 32'h0);
      chk("late idle lat_d",  32'(lat_d_a),  32'h6);
      chk("late idle busy",   32'(busy_a),   32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
